aes_round_engine: RTL and testbench
===================================

// Module: aes_round_engine
// PURPOSE
//  Iterative block-cipher datapath feeding the round-key accumulator: accepts one 128-bit block + 256-bit key,
//  drives the accumulator's key/next/encdec/round inputs, consumes its 128-bit round_key each round and applies
//  the round function NUM_ROUNDS times. Result returned with valid/ready handshake; one block in flight.
// PARAMETERS
//  NUM_ROUNDS  8  rounds per block (1..15; round port is 4 bits)
//  KEY_LAT     2  cycles from key_next pulse to first usable round_key (>=1)
//  ROT         1  left-rotate amount of round function (1..127)
// PORTS
//  clk           in   1    clock; all state updates on rising edge
//  reset         in   1    synchronous, active-high reset
//  start         in   1    request; accepted when start && ready
//  ready         out  1    engine idle, can accept start
//  encdec        in   1    1 = encrypt, 0 = decrypt; sampled on accept
//  key_in        in   256  cipher key; sampled on accept
//  block_in      in   128  input block; sampled on accept
//  key           out  256  registered key to accumulator, stable for whole operation
//  key_next      out  1    one-cycle load pulse to accumulator
//  key_encdec    out  1    registered encdec to accumulator
//  round         out  4    current round index to accumulator
//  round_key     in   128  round key for `round`, combinational, valid same cycle
//  result        out  128  output block
//  result_valid  out  1    result held valid until result_ready
//  result_ready  in   1    downstream accepts result
//  busy          out  1    ~ready
// BEHAVIOUR
//  Reset: FSM=IDLE; ready=1, busy=0, key_next=0, round=0, result_valid=0, result=0, key=0, key_encdec=0, state reg=0.
//   Reset mid-operation aborts immediately; no result produced; accumulator re-primed by next key_next.
//  FSM: IDLE -> LOAD -> ROUND -> DONE -> IDLE.
//   IDLE: ready=1. On start: latch block_in->s, key_in->key, encdec->key_encdec; go LOAD. start while not IDLE ignored.
//   LOAD: KEY_LAT cycles; key_next=1 in first LOAD cycle only; round=0; s unchanged.
//   ROUND: counter r = 0..NUM_ROUNDS-1, one per cycle; round=r; s updates at end of each cycle:
//    encrypt: s <= rotl(s ^ round_key, ROT)
//    decrypt: s <= rotr(s, ROT) ^ round_key   (accumulator supplies keys in reverse order for decrypt)
//    After r=NUM_ROUNDS-1: result<=s_new, result_valid<=1, go DONE.
//   DONE: round holds last value; result_valid=1 and result stable until result_ready=1; that cycle clear
//    result_valid, go IDLE (ready=1 next cycle). Back-to-back start accepted first cycle ready=1.
//  Latency: accept at cycle 0 -> result_valid at cycle 1+KEY_LAT+NUM_ROUNDS (11 at defaults).
//  Widths: XOR/rotate strictly 128-bit, rotation wraps bit 127<->0; round counter 4-bit, never exceeds NUM_ROUNDS-1.
//  key, key_encdec constant from LOAD through DONE; change only on accept or reset.
//  result_ready ignored outside DONE; start && result_ready in DONE: only the handshake completes, start ignored.
// TESTING
//  Reset mid-ROUND (r=4): next cycle ready=1, result_valid=0, round=0; no spurious result_valid afterwards.
//  Bench key model rk=128'h1 all rounds, encrypt, block 0 -> result 128'h1FE at cycle 11; key_next high cycle 1 only.
//  Same model, decrypt, block 128'h1FE -> result 128'h0; round sequence 0..7 on port, key_encdec=0 throughout.
//  result_ready held low 5 cycles in DONE -> result_valid and result stable 5 cycles, ready=0, start ignored.
//  Two blocks, start asserted continuously, result_ready=1 -> second accepted cycle after handshake; results in order.
//  With real accumulator, random key/block: encrypt then decrypt returns original block (1000 vectors).

Source files
------------

// File: rtl/aes_round_engine.sv
// -----------------------------------------------------------------------------
// aes_round_engine
//
// Iterative block-cipher datapath that works alongside an external round-key
// accumulator. It accepts one 128-bit block and one 256-bit key per operation.
// It primes the accumulator with a key_next pulse and waits KEY_LAT cycles.
// It then applies the round function NUM_ROUNDS times, using the accumulator's
// round_key for the current round index. The result is returned through a
// valid/ready handshake. Only one block is in flight at a time.
//
// Round function (strictly 128-bit, rotations wrap bit 127 <-> bit 0):
//   encrypt : s <= rotl(s ^ round_key, ROT)
//   decrypt : s <= rotr(s, ROT) ^ round_key
//
// Ports
//   clk           in   1    clock, rising edge
//   reset         in   1    synchronous active-high reset
//   start         in   1    request, accepted when start && ready
//   ready         out  1    idle, able to accept start
//   encdec        in   1    1 = encrypt, 0 = decrypt (sampled on accept)
//   key_in        in   256  cipher key (sampled on accept)
//   block_in      in   128  input block (sampled on accept)
//   key           out  256  registered key to the accumulator
//   key_next      out  1    one-cycle load pulse to the accumulator
//   key_encdec    out  1    registered direction to the accumulator
//   round         out  4    current round index to the accumulator
//   round_key     in   128  round key for `round`, valid in the same cycle
//   result        out  128  output block
//   result_valid  out  1    held until result_ready
//   result_ready  in   1    downstream accepts the result
//   busy          out  1    ~ready
// -----------------------------------------------------------------------------
module aes_round_engine #(
    parameter int NUM_ROUNDS = 8,   // 1..15
    parameter int KEY_LAT    = 2,   // >= 1
    parameter int ROT        = 1    // 1..127
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         ready,
    input  logic         encdec,
    input  logic [255:0] key_in,
    input  logic [127:0] block_in,
    output logic [255:0] key,
    output logic         key_next,
    output logic         key_encdec,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] result,
    output logic         result_valid,
    input  logic         result_ready,
    output logic         busy
);

    localparam int          LAT_W      = (KEY_LAT > 1) ? $clog2(KEY_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(KEY_LAT - 1);
    localparam logic [3:0]       ROUND_LAST = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [127:0]       s_q, s_d;
    logic [255:0]       key_q, key_d;
    logic               encdec_q, encdec_d;
    logic [3:0]         round_q, round_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [127:0]       result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic [127:0]       s_new;

    function automatic logic [127:0] rotl(input logic [127:0] x);
        return (x << ROT) | (x >> (128 - ROT));
    endfunction

    function automatic logic [127:0] rotr(input logic [127:0] x);
        return (x >> ROT) | (x << (128 - ROT));
    endfunction

    // Decrypt relies on the accumulator supplying keys in reverse order, so
    // the engine only mirrors the per-round operation.
    assign s_new = encdec_q ? rotl(s_q ^ round_key) : (rotr(s_q) ^ round_key);

    // NOTE: every variable driven here gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        s_d            = s_q;
        key_d          = key_q;
        encdec_d       = encdec_q;
        round_d        = round_q;
        lat_d          = lat_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    s_d      = block_in;
                    key_d    = key_in;
                    encdec_d = encdec;
                    round_d  = '0;
                    lat_d    = '0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                // Wait out the accumulator latency; s and round stay put.
                if (lat_q == LAT_LAST) begin
                    state_d = ROUND;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ROUND: begin
                s_d = s_new;
                if (round_q == ROUND_LAST) begin
                    // round is left at its last value for the DONE phase.
                    result_d       = s_new;
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                // start is deliberately ignored here; only the handshake ends DONE.
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            s_q            <= '0;
            key_q          <= '0;
            encdec_q       <= 1'b0;
            round_q        <= '0;
            lat_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            s_q            <= s_d;
            key_q          <= key_d;
            encdec_q       <= encdec_d;
            round_q        <= round_d;
            lat_q          <= lat_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign ready        = (state_q == IDLE);
    assign busy         = ~ready;
    assign key_next     = (state_q == LOAD) && (lat_q == '0);
    assign key          = key_q;
    assign key_encdec   = encdec_q;
    assign round        = round_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// -----------------------------------------------------------------------------
// tb_aes_round_engine
//
// Directed bench for aes_round_engine at default parameters. A small
// behavioural accumulator drives round_key: either the constant 128'h1 or a
// key/round hash that is replayed in reverse order for decrypt.
// -----------------------------------------------------------------------------
module tb_aes_round_engine;

    localparam int NR = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         ready;
    logic         encdec;
    logic [255:0] key_in;
    logic [127:0] block_in;
    logic [255:0] key;
    logic         key_next;
    logic         key_encdec;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] result;
    logic         result_valid;
    logic         result_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    logic km = 1'b0;   // 0: constant key 128'h1, 1: hashed key model

    aes_round_engine dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ready        (ready),
        .encdec       (encdec),
        .key_in       (key_in),
        .block_in     (block_in),
        .key          (key),
        .key_next     (key_next),
        .key_encdec   (key_encdec),
        .round        (round),
        .round_key    (round_key),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] model_rk(input logic [255:0] k, input int idx);
        logic [127:0] h;
        int a;
        h = k[255:128];
        a = idx * 9 + 1;
        return k[127:0] ^ ((h << a) | (h >> (128 - a))) ^ {124'h0, 4'(idx)};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [255:0] k, input logic [127:0] b);
        logic [127:0] s;
        s = b;
        for (int r = 0; r < NR; r++) begin
            s = s ^ model_rk(k, r);
            s = {s[126:0], s[127]};
        end
        return s;
    endfunction

    always_comb begin
        round_key = 128'h1;
        if (km)
            round_key = model_rk(key, key_encdec ? int'(round) : (NR - 1 - int'(round)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation from IDLE, wait for the result, complete the handshake.
    task automatic run_op(input logic ed, input logic [255:0] k, input logic [127:0] b,
                          output logic [127:0] res, output int lat);
        int n;
        start = 1'b1; encdec = ed; key_in = k; block_in = b;
        tick();
        start = 1'b0;
        n = 1;
        while (!result_valid && n < 100) begin
            tick();
            n++;
        end
        res = result;
        lat = n;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    initial begin
        logic [255:0] k1, k2, kr;
        logic [127:0] ra, rb, br, enc_res, dec_res;
        logic         spurious;
        int           lat;

        k1 = {8{32'hA5C3_0F17}};
        k2 = {8{32'h1234_9876}};
        reset = 1'b1; start = 1'b0; encdec = 1'b0; key_in = '0; block_in = '0;
        result_ready = 1'b0;

        // ---- reset state ------------------------------------------------
        tick(); tick();
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_key_next", key_next, 0);
        check("rst_round", round, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_key", key, 0);
        check("rst_encdec", key_encdec, 0);
        reset = 1'b0;
        tick();

        // ---- encrypt, constant key, block 0 -> 1FE at cycle 11 -----------
        km = 1'b0;
        start = 1'b1; encdec = 1'b1; key_in = k1; block_in = '0;
        tick();
        start = 1'b0; block_in = '1; key_in = k2; encdec = 1'b0;
        check("c1_key_next", key_next, 1);
        check("c1_key", key, k1);
        check("c1_encdec", key_encdec, 1);
        check("c1_round", round, 0);
        check("c1_busy", busy, 1);
        check("c1_ready", ready, 0);
        for (int cyc = 2; cyc <= 10; cyc++) begin
            tick();
            check("enc_key_next_low", key_next, 0);
            check("enc_no_early_valid", result_valid, 0);
            check("enc_key_stable", key, k1);
            if (cyc >= 3) check("enc_round_seq", round, 4'(cyc - 3));
            else check("enc_load_round", round, 0);
        end
        tick();
        check("enc_valid_c11", result_valid, 1);
        check("enc_result", result, 128'h1FE);
        check("enc_done_round", round, 7);

        // ---- DONE stall: result_ready low, start high -------------------
        start = 1'b1; block_in = 128'hDEAD; key_in = k2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", result_valid, 1);
            check("stall_result", result, 128'h1FE);
            check("stall_ready", ready, 0);
            check("stall_key", key, k1);
            check("stall_round", round, 7);
        end
        result_ready = 1'b1;   // start still high: only the handshake completes
        tick();
        check("hs_ready", ready, 1);
        check("hs_valid_clr", result_valid, 0);
        check("hs_start_ignored_key", key, k1);
        start = 1'b0; result_ready = 1'b0;
        tick();
        check("hs_still_idle", ready, 1);

        // ---- decrypt, constant key, 1FE -> 0 ----------------------------
        start = 1'b1; encdec = 1'b0; key_in = k2; block_in = 128'h1FE;
        tick();
        start = 1'b0; encdec = 1'b1;
        check("dec_key_next", key_next, 1);
        check("dec_encdec", key_encdec, 0);
        for (int cyc = 2; cyc <= 10; cyc++) begin
            tick();
            check("dec_encdec_hold", key_encdec, 0);
            if (cyc >= 3) check("dec_round_seq", round, 4'(cyc - 3));
        end
        tick();
        check("dec_valid_c11", result_valid, 1);
        check("dec_result", result, 0);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;

        // ---- reset in the middle of ROUND (r=4) -------------------------
        start = 1'b1; encdec = 1'b1; key_in = k1; block_in = 128'h55;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid_pre_round4", round, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_ready", ready, 1);
        check("mid_valid", result_valid, 0);
        check("mid_round", round, 0);
        check("mid_key", key, 0);
        spurious = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (result_valid || !ready) spurious = 1'b1;
        end
        check("mid_no_spurious", spurious, 0);

        // ---- back-to-back with start held high --------------------------
        km = 1'b1;
        result_ready = 1'b1;
        start = 1'b1; encdec = 1'b1; key_in = k1; block_in = 128'h0123_4567_89AB_CDEF;
        tick();
        block_in = 128'hFEDC_BA98_7654_3210; key_in = k2;
        lat = 1;
        while (!result_valid && lat < 100) begin tick(); lat++; end
        check("b2b_lat_a", lat, 11);
        check("b2b_result_a", result, ref_enc(k1, 128'h0123_4567_89AB_CDEF));
        check("b2b_busy_a", ready, 0);
        tick();
        check("b2b_idle_gap", ready, 1);
        check("b2b_valid_clr", result_valid, 0);
        tick();
        start = 1'b0;
        check("b2b_accept_b", ready, 0);
        check("b2b_key_next_b", key_next, 1);
        check("b2b_key_b", key, k2);
        lat = 1;
        while (!result_valid && lat < 100) begin tick(); lat++; end
        check("b2b_lat_b", lat, 11);
        check("b2b_result_b", result, ref_enc(k2, 128'hFEDC_BA98_7654_3210));
        tick();
        result_ready = 1'b0;

        // ---- random encrypt/decrypt round trips -------------------------
        for (int v = 0; v < 1000; v++) begin
            kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            br = {$urandom, $urandom, $urandom, $urandom};
            run_op(1'b1, kr, br, enc_res, lat);
            check("rnd_enc_lat", lat, 11);
            check("rnd_enc", enc_res, ref_enc(kr, br));
            run_op(1'b0, kr, enc_res, dec_res, lat);
            check("rnd_roundtrip", dec_res, br);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
